// File: rtl/fp_unpack_pipe.sv
// Two-stage IEEE-754 unpacker: sign, unbiased exponent, normalised significand.
// Classifies operands one-hot and keeps a saturating sNaN count.
module fp_unpack_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_sign,
  output logic [EXP_W+1:0]       out_exp,
  output logic [MAN_W:0]         out_sig,
  output logic [5:0]             out_class,
  output logic [CNT_W-1:0]       snan_cnt,
  input  logic                   cnt_clr
);

  localparam int EW   = EXP_W + 2;
  localparam int LZ_W = $clog2(MAN_W + 1);

  localparam logic [EW-1:0] BIAS_V = EW'(2**(EXP_W-1) - 1);
  localparam logic [EW-1:0] EMAX_V = EW'(2**(EXP_W-1));

  typedef struct packed {
    logic             sgn;
    logic [EXP_W-1:0] e;
    logic [MAN_W-1:0] m;
    logic [5:0]       cls;
    logic [LZ_W-1:0]  lz;
  } s1_t;

  logic             w_sgn;
  logic [EXP_W-1:0] w_e;
  logic [MAN_W-1:0] w_m;
  logic             w_e_zero;
  logic             w_e_max;
  logic             w_m_zero;
  logic [5:0]       w_cls;
  logic [LZ_W-1:0]  w_lz;
  logic             w_s2_adv;
  logic             w_in_fire;
  logic [MAN_W-1:0] w_shf;
  logic [EW-1:0]    w_exp;
  logic [MAN_W:0]   w_sig;

  logic r_s1_vld;
  s1_t  r_s1;
  logic r_s2_vld;

  assign w_sgn    = in_data[EXP_W+MAN_W];
  assign w_e      = in_data[EXP_W+MAN_W-1:MAN_W];
  assign w_m      = in_data[MAN_W-1:0];
  assign w_e_zero = ~|w_e;
  assign w_e_max  = &w_e;
  assign w_m_zero = ~|w_m;

  assign w_s2_adv  = !r_s2_vld || out_ready;
  assign in_ready  = !r_s1_vld || w_s2_adv;
  assign w_in_fire = in_valid && in_ready;
  assign out_valid = r_s2_vld;

  always_comb begin
    w_cls = '0;
    unique case (1'b1)
      w_e_zero && w_m_zero:                w_cls[0] = 1'b1;
      w_e_zero && !w_m_zero:               w_cls[2] = 1'b1;
      w_e_max && w_m_zero:                 w_cls[3] = 1'b1;
      w_e_max && w_m[MAN_W-1]:             w_cls[4] = 1'b1;
      w_e_max && !w_m_zero && !w_m[MAN_W-1]: w_cls[5] = 1'b1;
      default:                             w_cls[1] = 1'b1;
    endcase
  end

  // Last hit wins, so the most significant set bit sets the count.
  always_comb begin
    w_lz = LZ_W'(MAN_W);
    for (int i = 0; i < MAN_W; i++) begin
      if (w_m[i]) w_lz = LZ_W'(MAN_W - 1 - i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_vld <= 1'b0;
      r_s1     <= '{sgn: 1'b0, e: '0, m: '0, cls: 6'b000001, lz: '0};
    end else if (in_ready) begin
      r_s1_vld <= in_valid;
      if (in_valid) begin
        r_s1 <= '{sgn: w_sgn, e: w_e, m: w_m, cls: w_cls, lz: w_lz};
      end
    end
  end

  // Shift out the leading one of a subnormal fraction.
  assign w_shf = (r_s1.m << r_s1.lz) << 1;

  always_comb begin
    w_exp = {2'b00, r_s1.e} - BIAS_V;
    w_sig = {1'b1, r_s1.m};
    unique case (1'b1)
      r_s1.cls[0]: begin
        w_exp = '0;
        w_sig = '0;
      end
      r_s1.cls[2]: begin
        w_exp = '0 - BIAS_V - {{(EW-LZ_W){1'b0}}, r_s1.lz};
        w_sig = {1'b1, w_shf};
      end
      r_s1.cls[3]: begin
        w_exp = EMAX_V;
        w_sig = {1'b1, {MAN_W{1'b0}}};
      end
      r_s1.cls[4] || r_s1.cls[5]: begin
        w_exp = EMAX_V;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_vld  <= 1'b0;
      out_sign  <= 1'b0;
      out_exp   <= '0;
      out_sig   <= '0;
      out_class <= 6'b000001;
    end else if (w_s2_adv) begin
      r_s2_vld <= r_s1_vld;
      if (r_s1_vld) begin
        out_sign  <= r_s1.sgn;
        out_exp   <= w_exp;
        out_sig   <= w_sig;
        out_class <= r_s1.cls;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snan_cnt <= '0;
    end else if (cnt_clr) begin
      snan_cnt <= '0;
    end else if (w_in_fire && w_cls[5] && (snan_cnt != '1)) begin
      snan_cnt <= snan_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fp_unpack_pipe.sv
// Bench for fp_unpack_pipe: float-semantics model, per-cycle scoreboard,
// directed literal vectors, plus a half-precision instance.
module tb_fp_unpack_pipe;

  typedef struct {
    logic       s;
    longint     e;
    longint     sig;
    logic [5:0] c;
  } mres_t;

  logic        clk = 0;
  logic        rst_n = 0;
  logic        in_valid = 0;
  logic        in_ready;
  logic [31:0] in_data = 0;
  logic        out_valid;
  logic        out_ready = 1;
  logic        out_sign;
  logic [9:0]  out_exp;
  logic [23:0] out_sig;
  logic [5:0]  out_class;
  logic [1:0]  snan_cnt;
  logic        cnt_clr = 0;

  logic        b_in_valid = 0;
  logic        b_in_ready;
  logic [15:0] b_in_data = 0;
  logic        b_out_valid;
  logic        b_out_ready = 1;
  logic        b_sign;
  logic [6:0]  b_exp;
  logic [10:0] b_sig;
  logic [5:0]  b_cls;
  logic [15:0] b_cnt;
  logic        b_clr = 0;

  int n_vec = 0;
  int n_err = 0;
  int npop = 0;
  int ecnt = 0;
  mres_t q[$];

  always #5 clk = ~clk;

  fp_unpack_pipe #(.EXP_W(8), .MAN_W(23), .CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sign(out_sign), .out_exp(out_exp), .out_sig(out_sig),
    .out_class(out_class), .snan_cnt(snan_cnt), .cnt_clr(cnt_clr)
  );

  fp_unpack_pipe #(.EXP_W(5), .MAN_W(10), .CNT_W(16)) dut_h (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_sign(b_sign), .out_exp(b_exp), .out_sig(b_sig),
    .out_class(b_cls), .snan_cnt(b_cnt), .cnt_clr(b_clr)
  );

  task automatic chk(string nm, logic signed [63:0] act,
                     logic signed [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  // Value-level view: subnormal = M * 2^(1-bias-mw), renormalised.
  function automatic mres_t mdl(int ew, int mw, longint unsigned x);
    mres_t r;
    longint unsigned m, e, emax;
    longint bias;
    int p;
    m    = x & ((64'd1 << mw) - 1);
    e    = (x >> mw) & ((64'd1 << ew) - 1);
    r.s  = logic'((x >> (ew + mw)) & 1);
    bias = (longint'(1) <<< (ew - 1)) - 1;
    emax = (64'd1 << ew) - 1;
    if (e == 0 && m == 0) begin
      r.e = 0; r.sig = 0; r.c = 6'b000001;
    end else if (e == 0) begin
      p = 0;
      for (int i = 0; i < mw; i++) if (m[i]) p = i;
      r.e   = longint'(p) + 1 - bias - longint'(mw);
      r.sig = longint'((m << (mw - p)) & ((64'd1 << (mw + 1)) - 1));
      r.c   = 6'b000100;
    end else if (e == emax) begin
      r.e   = bias + 1;
      r.sig = longint'(m | (64'd1 << mw));
      if (m == 0) r.c = 6'b001000;
      else if (((m >> (mw - 1)) & 1) == 1) r.c = 6'b010000;
      else r.c = 6'b100000;
    end else begin
      r.e   = longint'(e) - bias;
      r.sig = longint'(m | (64'd1 << mw));
      r.c   = 6'b000010;
    end
    return r;
  endfunction

  always @(negedge clk) begin
    mres_t h;
    mres_t m;
    bit fire;
    if (!rst_n) begin
      q.delete();
      ecnt = 0;
      chk("rst_out_valid", out_valid, 0);
    end else begin
      chk("snan_cnt", snan_cnt, ecnt);
      if (out_valid) begin
        if (q.size() == 0) chk("spurious_out", 1, 0);
        else begin
          h = q[0];
          chk("sb_sign", out_sign, h.s);
          chk("sb_exp", $signed(out_exp), h.e);
          chk("sb_sig", out_sig, h.sig);
          chk("sb_class", out_class, h.c);
          if (out_ready) begin
            void'(q.pop_front());
            npop++;
          end
        end
      end
      fire = in_valid && in_ready;
      m = mdl(8, 23, in_data);
      if (fire) q.push_back(m);
      if (cnt_clr) ecnt = 0;
      else if (fire && m.c == 6'b100000 && ecnt < 3) ecnt++;
    end
  end

  task automatic send(input logic [31:0] x, input logic clr);
    bit ok = 0;
    in_data = x;
    in_valid = 1;
    cnt_clr = clr;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 0;
    cnt_clr = 0;
    if (!ok) chk("send_timeout", 0, 1);
  endtask

  task automatic lit(string nm, logic s, longint e, longint sig,
                     logic [5:0] c, int want_k);
    int k = 0;
    bit got = 0;
    while (!got && k < 10) begin
      @(negedge clk);
      k++;
      got = out_valid && out_ready;
    end
    chk({nm, "_seen"}, got, 1);
    if (want_k > 0) chk({nm, "_lat"}, k, want_k);
    chk({nm, "_sign"}, out_sign, s);
    chk({nm, "_exp"}, $signed(out_exp), e);
    chk({nm, "_sig"}, out_sig, sig);
    chk({nm, "_class"}, out_class, c);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    mres_t r;
    logic [31:0] ops[5];
    int idx, p0;
    bit got;

    r = mdl(8, 23, 64'h1);
    chk("pin_sub_min_exp", r.e, -149);
    r = mdl(8, 23, 64'h7FFFFF);
    chk("pin_sub_max_sig", r.sig, 64'hFFFFFE);
    r = mdl(8, 23, 64'h7FA00000);
    chk("pin_snan_class", r.c, 6'b100000);
    r = mdl(5, 10, 64'h1);
    chk("pin_h_sub_exp", r.e, -24);

    #12;
    chk("rst_valid", out_valid, 0);
    chk("rst_class", out_class, 6'b000001);
    chk("rst_exp", out_exp, 0);
    chk("rst_sig", out_sig, 0);
    chk("rst_cnt", snan_cnt, 0);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    rst_n = 1;
    @(posedge clk);
    #1;
    chk("post_rst_ready", in_ready, 1);

    send(32'h3F800000, 0);
    lit("one", 0, 0, 'h800000, 6'b000010, 2);

    send(32'h00000001, 0);
    send(32'h007FFFFF, 0);
    lit("sub_min", 0, -149, 'h800000, 6'b000100, 1);
    lit("sub_max", 0, -127, 'hFFFFFE, 6'b000100, 1);

    chk("cnt_before", snan_cnt, 0);
    send(32'hFF800000, 0);
    lit("ninf", 1, 128, 'h800000, 6'b001000, 2);
    send(32'h7FC00000, 0);
    lit("qnan", 0, 128, 'hC00000, 6'b010000, 2);
    send(32'h7FA00000, 0);
    lit("snan", 0, 128, 'hA00000, 6'b100000, 2);
    chk("cnt_after", snan_cnt, 1);
    send(32'h80000000, 0);
    lit("nzero", 1, 0, 0, 6'b000001, 2);

    ops = '{32'h3F800000, 32'h40000000, 32'hC0400000,
            32'h00400000, 32'h7F7FFFFF};
    p0 = npop;
    out_ready = 0;
    idx = 0;
    in_valid = 1;
    in_data = ops[0];
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (in_ready) idx++;
      @(posedge clk);
      #1;
      in_data = ops[idx];
    end
    chk("bp_accepted", idx, 2);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_held_sig", out_sig, 'h800000);
    out_ready = 1;
    for (int c = 0; c < 20 && idx < 5; c++) begin
      @(negedge clk);
      if (in_ready) idx++;
      @(posedge clk);
      #1;
      if (idx < 5) in_data = ops[idx];
      else in_valid = 0;
    end
    in_valid = 0;
    repeat (4) @(posedge clk);
    #1;
    chk("bp_drained", q.size(), 0);
    chk("bp_pops", npop - p0, 5);

    for (int i = 0; i < 5; i++) send(32'h7F800001, 0);
    @(posedge clk);
    #1;
    chk("cnt_sat", snan_cnt, 3);
    send(32'h7FA00000, 1);
    chk("cnt_clr_prio", snan_cnt, 0);
    repeat (4) @(posedge clk);
    #1;

    send(32'h3F800000, 0);
    send(32'h40000000, 0);
    chk("inflight_valid", out_valid, 1);
    rst_n = 0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_sign", out_sign, 0);
    chk("arst_exp", out_exp, 0);
    chk("arst_sig", out_sig, 0);
    chk("arst_class", out_class, 6'b000001);
    @(posedge clk);
    #1;
    rst_n = 1;
    send(32'h3F800000, 0);
    lit("after_rst", 0, 0, 'h800000, 6'b000010, 2);

    b_in_valid = 1;
    b_in_data = 16'h0001;
    @(negedge clk);
    chk("h_ready", b_in_ready, 1);
    @(posedge clk);
    #1;
    b_in_data = 16'h3C00;
    @(posedge clk);
    #1;
    b_in_valid = 0;
    got = 0;
    for (int k = 0; k < 6 && !got; k++) begin
      @(negedge clk);
      got = b_out_valid;
    end
    chk("h_sub_seen", got, 1);
    chk("h_sub_exp", $signed(b_exp), -24);
    chk("h_sub_sig", b_sig, 'h400);
    chk("h_sub_class", b_cls, 6'b000100);
    @(negedge clk);
    chk("h_one_seen", b_out_valid, 1);
    chk("h_one_exp", $signed(b_exp), 0);
    chk("h_one_sig", b_sig, 'h400);
    chk("h_one_class", b_cls, 6'b000010);

    repeat (3) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fp_unpack_pipe.md
Name: fp_unpack_pipe

Overview:
- Parametrised, pipelined IEEE-754 unpacker for the FP datapath front end.
- Accepts packed binary floats of any exponent/mantissa width and splits them into sign, unbiased exponent and explicit-hidden-bit significand. Subnormals are normalised by leading-zero count.
- Also classifies each operand and counts signalling NaNs.
- Sits between the operand register file and the adder/multiplier datapaths, with valid/ready handshakes on both sides.

Parameters:
- EXP_W, 8, exponent field width.
- MAN_W, 23, fraction field width. Constraint: MAN_W < 2**EXP_W.
- CNT_W, 16, width of the sNaN event counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input operand valid.
- in_ready  out  1  block can accept an operand this cycle.
- in_data  in  1+EXP_W+MAN_W  packed float, {sign, exponent, fraction}.
- out_valid  out  1  unpacked result valid.
- out_ready  in  1  downstream accepts the result.
- out_sign  out  1  sign bit.
- out_exp  out  EXP_W+2  signed unbiased exponent.
- out_sig  out  MAN_W+1  significand with explicit leading bit.
- out_class  out  6  one-hot {snan, qnan, inf, subnormal, normal, zero}, bit 5 = snan.
- snan_cnt  out  CNT_W  saturating count of sNaNs accepted.
- cnt_clr  in  1  synchronous clear of snan_cnt.

Behaviour:
- Constant BIAS = 2**(EXP_W-1)-1. Field E = exponent, M = fraction.
- Pipeline structure: 2 stages (S1, S2). Latency is exactly 2 cycles from input handshake to out_valid when unstalled. Throughput is 1 operand per cycle.
  - S1 registers in_data, class and lz.
  - lz = leading-zero count of M, range 0..MAN_W (MAN_W when M==0).
  - S2 registers out_* from S1.
- Handshake:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - S2 advances when !out_valid || out_ready.
  - S1 advances into S2 when S1 is valid and S2 advances.
  - in_ready = !s1_valid || s2_advance. This is a combinational path from out_ready, which is permitted.
  - With out_valid=1 and out_ready=0, all out_* hold stable. No bubble is inserted on resume.
- Classification and outputs:
  - Zero (E==0, M==0): exp=0, sig=0.
  - Subnormal (E==0, M!=0):
    - exp = -BIAS - lz.
    - sig = {1'b1, (M << (lz+1))[MAN_W-1:0]}.
  - Normal (0<E<all-ones): exp = E - BIAS, sig = {1'b1, M}.
  - Inf (E all-ones, M==0): exp = BIAS+1, sig = {1'b1, 0}.
  - NaN (E all-ones, M!=0): exp = BIAS+1, sig = {1'b1, M}.
    - qnan if M[MAN_W-1]=1.
    - snan otherwise.
  - out_sign always passes through unchanged, including for zero and NaN.
- Exponent arithmetic is signed, EXP_W+2 bits, with no overflow for legal parameters. For EXP_W=8, MAN_W=23 the range is -149..+128.
- snan_cnt:
  - Increments on each input handshake whose operand is an sNaN. Classification happens at S1 capture.
  - Saturates at all-ones and does not wrap.
  - cnt_clr has priority over a simultaneous increment; the result is 0.
- Reset (asynchronous, any cycle, including mid-stream):
  - S1/S2 valid flags = 0 and out_valid = 0.
  - out_sign = 0, out_exp = 0, out_sig = 0, out_class = 6'b000001 (zero), snan_cnt = 0.
  - In-flight operands are discarded.
  - in_ready is 1 one cycle after reset deassertion at the latest; combinationally it is 1 whenever S1 is empty.
- Simultaneous input and output transfer on a full pipeline: both occur in the same cycle and occupancy is unchanged.

Test Plan:
- 0x3F800000 (1.0) with out_ready=1 -> 2 cycles later: out_sign=0, out_exp=0, out_sig=0x800000, class=normal.
- 0x00000001 then 0x007FFFFF back-to-back:
  - first -> exp=-149, sig=0x800000, subnormal;
  - second -> exp=-127, sig=0xFFFFFE, subnormal;
  - results on consecutive cycles.
- Specials:
  - 0xFF800000 -> sign=1, exp=128, sig=0x800000, inf.
  - 0x7FC00000 -> qnan.
  - 0x7FA00000 -> snan, snan_cnt 0->1.
  - 0x80000000 -> sign=1, zero.
- Backpressure:
  - Stream 5 operands with out_ready=0 for 4 cycles -> in_ready drops after 2 accepted; outputs held stable.
  - Release -> all 5 emerge in order with no loss or duplicate.
- Counter:
  - CNT_W=2: feed 5 sNaNs -> snan_cnt saturates at 3.
  - cnt_clr asserted coincident with an sNaN -> snan_cnt=0.
- Assert rst_n low with 2 operands in flight -> out_valid=0 immediately and outputs at reset values. After release, a new 1.0 input emerges with 2-cycle latency.
- Parameter sweep EXP_W=5, MAN_W=10:
  - 0x0001 -> exp=-24, sig=0x400, subnormal.
  - 0x3C00 -> exp=0, sig=0x400, normal.
